pipelined_subtractor: RTL and testbench



---
 rtl/sub_pkg.sv | 34 +++
 rtl/ripple_carry_adder.sv | 41 ++++
 rtl/pipelined_subtractor.sv | 200 ++++++++++++++++++++
 tb/tb_pipelined_subtractor.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_pkg
// Description : Shared definitions for the block-pipelined subtractor:
//               default geometry, stage-count derivation, configuration
//               legality check and the status-flag bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 8;
    localparam int c_DEFAULT_BLOCK_SIZE = 2;

    // Status flags presented alongside the difference.
    typedef struct packed {
        logic bf;   // borrow out (unsigned A < B + Bin)
        logic of;   // signed overflow
        logic zf;   // difference is zero
        logic nf;   // difference sign bit
    } flags_t;

    // One pipeline stage resolves one BLOCK_SIZE-bit slice.
    function automatic int calc_stages(input int data_width, input int block_size);
        return data_width / block_size;
    endfunction

    // The operand must split into a whole number of slices.
    function automatic bit cfg_ok(input int data_width, input int block_size);
        return (block_size > 0) && (data_width >= block_size) &&
               ((data_width % block_size) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module      : ripple_carry_adder
// Description : Combinational ripple-carry adder with group propagate and
//               group generate outputs for use in carry-lookahead trees.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_adder #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Cin,
    output logic [DATA_WIDTH-1:0] S,
    output logic                  Cout,
    output logic                  P,
    output logic                  G
);

    // Bit-serial carry chain; G is the chain result with a zero carry-in.
    always_comb begin : p_ripple
        logic w_c;
        logic w_g;
        S    = '0;
        Cout = 1'b0;
        P    = 1'b1;
        G    = 1'b0;
        w_c  = Cin;
        w_g  = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            S[i] = A[i] ^ B[i] ^ w_c;
            w_c  = (A[i] & B[i]) | ((A[i] ^ B[i]) & w_c);
            w_g  = (A[i] & B[i]) | ((A[i] ^ B[i]) & w_g);
            P    = P & (A[i] ^ B[i]);
        end
        Cout = w_c;
        G    = w_g;
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_subtractor
// Description : Block-pipelined two's-complement subtractor D = A - B - Bin.
//               One BLOCK_SIZE slice is resolved per stage with the carry
//               registered between stages; valid/ready on both sides with
//               bubble-collapsing backpressure and registered status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_subtractor
    import sub_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int BLOCK_SIZE = c_DEFAULT_BLOCK_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] D,
    output logic                  BF,
    output logic                  OF,
    output logic                  ZF,
    output logic                  NF
);

    localparam int c_STAGES = calc_stages(DATA_WIDTH, BLOCK_SIZE);
    localparam int c_MSB    = DATA_WIDTH - 1;

    if (!cfg_ok(DATA_WIDTH, BLOCK_SIZE)) begin : g_cfg_check
        $error("pipelined_subtractor: DATA_WIDTH (%0d) must be a positive multiple of BLOCK_SIZE (%0d)",
               DATA_WIDTH, BLOCK_SIZE);
    end

    // ------------------------------------------------------------------
    // Handshake state
    // ------------------------------------------------------------------
    logic [c_STAGES-1:0] r_v;        // stage k holds a live operation
    logic [c_STAGES:0]   w_vchain;   // {stage valids, in_valid}
    logic [c_STAGES-1:0] w_up_v;     // valid of the upstream neighbour
    logic [c_STAGES-1:0] w_ready;    // stage k can take new data
    logic [c_STAGES-1:0] w_load;     // stage k captures this edge

    // Final-stage registered result
    logic [DATA_WIDTH-1:0] r_d_out;
    flags_t                r_flags;

    // Stage 0 is fed by the input port; stage k by stage k-1.
    assign w_vchain  = {r_v, in_valid};
    assign w_up_v    = w_vchain[c_STAGES-1:0];
    assign out_valid = w_vchain[c_STAGES];
    assign in_ready  = w_ready[0];

    // Ready chain ready[k] = ~v[k] | ready[k+1] flattened: a stage is ready
    // unless it and every stage downstream of it are full while the consumer
    // stalls. The flat form avoids a bit-to-bit loop within one vector.
    always_comb begin : p_ready
        logic w_full;
        w_ready = '0;
        w_load  = '0;
        w_full  = 1'b1;
        for (int k = 0; k < c_STAGES; k++) begin
            w_full = 1'b1;
            for (int j = k; j < c_STAGES; j++) begin
                w_full = w_full & r_v[j];
            end
            w_ready[k] = out_ready | ~w_full;
        end
        w_load = w_up_v & w_ready;
    end

    // Valid bits advance whenever a stage is ready; an empty upstream
    // neighbour leaves a bubble that the next ready stage will swallow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < c_STAGES; k++) begin
                if (w_ready[k]) begin
                    r_v[k] <= w_up_v[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath stages
    // ------------------------------------------------------------------
    for (genvar k = 0; k < c_STAGES; k++) begin : g_stage
        // Unresolved operand bits entering this stage and result bits known
        // after it.
        localparam int c_IN_W = DATA_WIDTH - k * BLOCK_SIZE;
        localparam int c_D_W  = (k + 1) * BLOCK_SIZE;

        logic [c_IN_W-1:0]     w_a_in;
        logic [c_IN_W-1:0]     w_nb_in;
        logic                  w_cin;
        logic                  w_amsb;
        logic                  w_bmsb;
        logic [BLOCK_SIZE-1:0] w_sum;
        logic                  w_cout;
        logic                  w_p_unused;
        logic                  w_g_unused;
        logic [c_D_W-1:0]      w_d;

        if (k == 0) begin : g_head
            // A - B - Bin is evaluated as A + ~B + ~Bin.
            assign w_a_in  = A;
            assign w_nb_in = ~B;
            assign w_cin   = ~Bin;
            assign w_amsb  = A[c_MSB];
            assign w_bmsb  = B[c_MSB];
            assign w_d     = w_sum;
        end else begin : g_body
            assign w_a_in  = g_stage[k-1].g_skew.r_a_rem;
            assign w_nb_in = g_stage[k-1].g_skew.r_nb_rem;
            assign w_cin   = g_stage[k-1].g_skew.r_c;
            assign w_amsb  = g_stage[k-1].g_skew.r_amsb;
            assign w_bmsb  = g_stage[k-1].g_skew.r_bmsb;
            assign w_d     = {w_sum, g_stage[k-1].g_skew.r_d};
        end

        ripple_carry_adder #(
            .DATA_WIDTH (BLOCK_SIZE)
        ) u_rca (
            .A    (w_a_in[BLOCK_SIZE-1:0]),
            .B    (w_nb_in[BLOCK_SIZE-1:0]),
            .Cin  (w_cin),
            .S    (w_sum),
            .Cout (w_cout),
            .P    (w_p_unused),
            .G    (w_g_unused)
        );

        if (k < c_STAGES - 1) begin : g_skew
            logic [c_IN_W-BLOCK_SIZE-1:0] r_a_rem;
            logic [c_IN_W-BLOCK_SIZE-1:0] r_nb_rem;
            logic [c_D_W-1:0]             r_d;
            logic                         r_c;
            logic                         r_amsb;
            logic                         r_bmsb;

            // Skew register: pass on the untouched upper slices, the result
            // bits resolved so far, the slice carry and the operand signs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_rem  <= '0;
                    r_nb_rem <= '0;
                    r_d      <= '0;
                    r_c      <= 1'b0;
                    r_amsb   <= 1'b0;
                    r_bmsb   <= 1'b0;
                end else if (w_load[k]) begin
                    r_a_rem  <= w_a_in[c_IN_W-1:BLOCK_SIZE];
                    r_nb_rem <= w_nb_in[c_IN_W-1:BLOCK_SIZE];
                    r_d      <= w_d;
                    r_c      <= w_cout;
                    r_amsb   <= w_amsb;
                    r_bmsb   <= w_bmsb;
                end
            end
        end else begin : g_tail
            flags_t w_flags;

            // Flags from the completed difference; borrow is the inverted
            // final carry because the subtraction runs as an addition.
            always_comb begin
                w_flags    = '0;
                w_flags.bf = ~w_cout;
                w_flags.of = (w_amsb ^ w_bmsb) & (w_d[c_MSB] ^ w_amsb);
                w_flags.zf = ~|w_d;
                w_flags.nf = w_d[c_MSB];
            end

            // Output register; holds while the consumer stalls.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_d_out <= '0;
                    r_flags <= '0;
                end else if (w_load[k]) begin
                    r_d_out <= w_d;
                    r_flags <= w_flags;
                end
            end
        end
    end

    assign D  = r_d_out;
    assign BF = r_flags.bf;
    assign OF = r_flags.of;
    assign ZF = r_flags.zf;
    assign NF = r_flags.nf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_subtractor
// Description : Scoreboard bench for pipelined_subtractor (8-bit, 2-bit
//               slices): directed vectors, latency, backpressure, randomized
//               traffic against an arithmetic reference, reset mid-stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_subtractor;

    localparam int c_LIMIT = 200;

    typedef struct packed {
        logic [7:0] d;
        logic       bf;
        logic       of;
        logic       zf;
        logic       nf;
    } res_t;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] A         = '0;
    logic [7:0] B         = '0;
    logic       Bin       = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] D;
    logic       BF, OF, ZF, NF;

    res_t sb[$];
    int   checks     = 0;
    int   failures   = 0;
    int   received   = 0;
    int   rmode      = 0;      // 0: always ready, 1: random, 2: manual
    logic manual_rdy = 1'b1;

    pipelined_subtractor #(
        .DATA_WIDTH (8),
        .BLOCK_SIZE (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .BF        (BF),
        .OF        (OF),
        .ZF        (ZF),
        .NF        (NF)
    );

    always #5 clk = ~clk;

    // Consumer readiness, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = manual_rdy;
        endcase
    end

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int   diff;
        int   sdiff;
        res_t r;
        diff  = int'(a) - int'(b) - int'(bin);
        sdiff = int'($signed(a)) - int'($signed(b)) - int'(bin);
        r.d   = diff[7:0];
        r.bf  = (diff < 0);
        r.of  = (sdiff < -128) || (sdiff > 127);
        r.zf  = (r.d == 8'h00);
        r.nf  = r.d[7];
        return r;
    endfunction

    function automatic res_t mk(input logic [7:0] d, input logic bf, input logic of,
                                input logic zf, input logic nf);
        return {d, bf, of, zf, nf};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Monitor: pops on every output transfer and checks hold-while-stalled.
    res_t mon_got;
    res_t mon_exp;
    res_t prev_val;
    logic prev_hold = 1'b0;
    always @(negedge clk) begin
        mon_got = {D, BF, OF, ZF, NF};
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (!out_valid || (mon_got !== prev_val)) begin
                    failures++;
                    $display("FAIL hold: got valid=%0b D=%h flags=%b, required valid=1 D=%h flags=%b",
                             out_valid, mon_got.d, mon_got[3:0], prev_val.d, prev_val[3:0]);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                received++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: got D=%h flags=%b, required no output",
                             mon_got.d, mon_got[3:0]);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_got !== mon_exp) begin
                        failures++;
                        $display("FAIL result: got D=%h BF=%b OF=%b ZF=%b NF=%b, required D=%h BF=%b OF=%b ZF=%b NF=%b",
                                 mon_got.d, mon_got.bf, mon_got.of, mon_got.zf, mon_got.nf,
                                 mon_exp.d, mon_exp.bf, mon_exp.of, mon_exp.zf, mon_exp.nf);
                    end
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_val  = mon_got;
        end
    end

    // Present one operand set; called and returns just after a rising edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bin, input res_t e);
        bit ok;
        ok       = 1'b0;
        A        = a;
        B        = b;
        Bin      = bin;
        in_valid = 1'b1;
        for (int t = 0; t < c_LIMIT; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            sb.push_back(e);
        end else begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required acceptance", c_LIMIT);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk({name, "_pending"}, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat;
        bit   seen;
        int   r0;
        logic [7:0] ra, rb;
        logic       rbin;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_D", D, 0);
        chk("reset_flags", {BF, OF, ZF, NF}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Latency of a lone operation
        send(8'h05, 8'h03, 1'b0, mk(8'h02, 0, 0, 0, 0));
        lat  = 1;
        seen = 1'b0;
        for (int t = 0; t < c_LIMIT; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        chk("latency", seen ? lat : -1, 4);
        @(posedge clk);
        #1;

        // Directed flag cases, back to back
        send(8'h03, 8'h05, 1'b0, mk(8'hFE, 1, 0, 0, 1));
        send(8'h80, 8'h01, 1'b0, mk(8'h7F, 0, 1, 0, 0));
        send(8'h7F, 8'hFF, 1'b0, mk(8'h80, 1, 1, 0, 1));
        send(8'h10, 8'h0F, 1'b1, mk(8'h00, 0, 0, 1, 0));
        send(8'h00, 8'h00, 1'b1, mk(8'hFF, 1, 0, 0, 1));
        drain("directed");

        // Backpressure: consumer stalled until 6 cycles into the first result
        manual_rdy = 1'b0;
        rmode      = 2;
        @(posedge clk);
        #1;
        r0 = received;
        fork
            begin
                for (int i = 1; i <= 8; i++) begin
                    send(8'(i), 8'h01, 1'b0, mk(8'(i - 1), 0, 0, (i == 1), 0));
                end
            end
            begin
                seen = 1'b0;
                for (int t = 0; t < c_LIMIT; t++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("bp_first_result", seen, 1);
                repeat (5) @(negedge clk);
                chk("bp_in_ready_full", in_ready, 0);
                chk("bp_accepted", sb.size(), 4);
                chk("bp_out_valid", out_valid, 1);
                manual_rdy = 1'b1;
            end
        join
        drain("backpressure");
        chk("bp_count", received - r0, 8);

        // Randomized traffic with random consumer stalls
        rmode = 1;
        r0    = received;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            send(ra, rb, rbin, model(ra, rb, rbin));
        end
        drain("random");
        chk("random_count", received - r0, 1000);

        // Reset with three operations in flight
        manual_rdy = 1'b0;
        rmode      = 2;
        @(posedge clk);
        #1;
        send(8'h30, 8'h10, 1'b0, mk(8'h20, 0, 0, 0, 0));
        send(8'h31, 8'h10, 1'b0, mk(8'h21, 0, 0, 0, 0));
        send(8'h32, 8'h10, 1'b0, mk(8'h22, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #2;
        chk("pre_reset_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_D", D, 0);
        chk("midreset_flags", {BF, OF, ZF, NF}, 0);
        rmode = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);
        chk("post_reset_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        r0 = received;
        send(8'h09, 8'h04, 1'b0, mk(8'h05, 0, 0, 0, 0));
        drain("post_reset");
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset_count", received - r0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
